// File: rtl/spi_pkg.sv
// Shared types and width helpers for the SPI chip-select transaction controller.
package spi_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, INACTIVE} spi_txn_state_t;

   // Bits needed to hold values 0..n inclusive.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/spi_cs_gap_timer.sv
// Loadable down-counter for CS setup/hold/inactive gaps; done_o marks the last cycle of the interval.
module spi_cs_gap_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   output logic         done_o,
   output logic         idle_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         run_q, run_d;

   always_comb begin
      cnt_d = cnt_q;
      run_d = run_q;
      if (load_i) begin
         cnt_d = val_i;
         run_d = 1'b1;
      end else if (run_q) begin
         if (cnt_q > W'(1)) begin
            cnt_d = cnt_q - W'(1);
         end else begin
            cnt_d = '0;
            run_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign done_o = run_q && (cnt_q == W'(1));
   assign idle_o = !run_q;

endmodule

// File: rtl/spi_cs_txn_ctrl.sv
// CS-framed multi-byte transaction controller feeding SPI_Master one byte at a time, RX bytes tagged by index.
// Optional idle-wait abort under `SPI_TXN_TIMEOUT_EN; without it the controller waits indefinitely for the next byte.
module spi_cs_txn_ctrl
   import spi_pkg::*;
#(
   parameter int MAX_BYTES_PER_CS = 2,
   parameter int CS_SETUP_CLKS    = 2,
   parameter int CS_HOLD_CLKS     = 2,
   parameter int CS_INACTIVE_CLKS = 4,
   parameter int TIMEOUT_CLKS     = 256,
   localparam int CW = cnt_w(MAX_BYTES_PER_CS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] i_TX_Count,
   input  logic [7:0]    i_TX_Byte,
   input  logic          i_TX_DV,
   output logic          o_TX_Ready,
   output logic [CW-1:0] o_RX_Count,
   output logic          o_RX_DV,
   output logic [7:0]    o_RX_Byte,
   output logic [7:0]    o_MOSI_Byte,
   output logic          o_MOSI_DV,
   input  logic          i_MOSI_Ready,
   input  logic          i_MISO_DV,
   input  logic [7:0]    i_MISO_Byte,
   output logic          o_CS_n,
   output logic          o_Abort
);

   localparam int            TW    = cnt_w(max3(CS_SETUP_CLKS, CS_HOLD_CLKS, CS_INACTIVE_CLKS));
   localparam logic [CW-1:0] MAX_C = CW'(MAX_BYTES_PER_CS);

   spi_txn_state_t state_q, state_d;
   logic           cs_n_q, cs_n_d;
   logic           tx_rdy_q, tx_rdy_d;
   logic           mosi_dv_q, mosi_dv_d;
   logic           abort_q, abort_d;
   logic           pend_q;
   logic [7:0]     byte_q;
   logic [CW-1:0]  cnt_q, idx_q, cnt_in;
   logic           rx_dv_q;
   logic [7:0]     rx_byte_q;
   logic [CW-1:0]  rx_cnt_q;
   logic           tmr_load, tmr_done, tmr_idle, gap_ok;
   logic [TW-1:0]  tmr_val;
   logic           accept, rx_hit, last_rx, tmo_hit;

   assign accept  = i_TX_DV && tx_rdy_q;
   assign rx_hit  = i_MISO_DV && (state_q == XFER);
   assign last_rx = rx_hit && ((idx_q + CW'(1)) == cnt_q);
   assign gap_ok  = tmr_done || tmr_idle;

`ifdef SPI_TXN_TIMEOUT_EN
   localparam int TMW = cnt_w(TIMEOUT_CLKS);
   logic [TMW-1:0] tmo_q;
   logic           tmo_run;

   // Runs only while waiting on upstream for the next byte of an open transaction.
   assign tmo_run = (state_q == XFER) && tx_rdy_q && !i_TX_DV;
   assign tmo_hit = tmo_run && (tmo_q == TMW'(TIMEOUT_CLKS - 1));

   always_ff @(posedge clk) begin
      if (!rst || !tmo_run) tmo_q <= '0;
      else if (!tmo_hit)    tmo_q <= tmo_q + TMW'(1);
   end
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT_CLKS > 0);
   assign tmo_hit    = 1'b0;
`endif

   always_comb begin
      cnt_in = i_TX_Count;
      if (i_TX_Count == '0)        cnt_in = CW'(1);
      else if (i_TX_Count > MAX_C) cnt_in = MAX_C;
   end

   spi_cs_gap_timer #(.W(TW)) u_gap_timer (
      .clk    (clk),
      .rst    (rst),
      .load_i (tmr_load),
      .val_i  (tmr_val),
      .done_o (tmr_done),
      .idle_o (tmr_idle)
   );

   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (accept)                  state_d = SETUP;
         SETUP:    if (gap_ok && i_MOSI_Ready)  state_d = XFER;
         XFER:     if (last_rx || tmo_hit)      state_d = HOLD;
         HOLD:     if (gap_ok)                  state_d = INACTIVE;
         INACTIVE: if (gap_ok)                  state_d = IDLE;
         default:                               state_d = IDLE;
      endcase
   end

   always_comb begin
      tmr_load  = 1'b0;
      tmr_val   = TW'(CS_SETUP_CLKS);
      cs_n_d    = cs_n_q;
      mosi_dv_d = 1'b0;
      abort_d   = 1'b0;
      unique case (state_q)
         IDLE: if (accept) begin
            tmr_load = 1'b1;
            cs_n_d   = 1'b0;
         end
         SETUP: mosi_dv_d = gap_ok && i_MOSI_Ready;
         XFER: begin
            mosi_dv_d = (pend_q || accept) && i_MOSI_Ready;
            abort_d   = tmo_hit;
            if (last_rx || tmo_hit) begin
               tmr_load = 1'b1;
               tmr_val  = TW'(CS_HOLD_CLKS);
            end
         end
         HOLD: if (gap_ok) begin
            cs_n_d   = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = TW'(CS_INACTIVE_CLKS);
         end
         default: ;
      endcase
      // Upstream ready reopens the cycle after each non-final MISO byte and closes on accept.
      tx_rdy_d = 1'b0;
      if (state_d == IDLE)                                tx_rdy_d = 1'b1;
      else if (state_q == XFER && state_d == XFER) begin
         if (rx_hit)      tx_rdy_d = 1'b1;
         else if (accept) tx_rdy_d = 1'b0;
         else             tx_rdy_d = tx_rdy_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cs_n_q    <= 1'b1;
         tx_rdy_q  <= 1'b0;
         mosi_dv_q <= 1'b0;
         abort_q   <= 1'b0;
         pend_q    <= 1'b0;
         byte_q    <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         rx_dv_q   <= 1'b0;
         rx_byte_q <= '0;
         rx_cnt_q  <= '0;
      end else begin
         cs_n_q    <= cs_n_d;
         tx_rdy_q  <= tx_rdy_d;
         mosi_dv_q <= mosi_dv_d;
         abort_q   <= abort_d;
         rx_dv_q   <= rx_hit;
         if (accept) byte_q <= i_TX_Byte;
         if (mosi_dv_d)   pend_q <= 1'b0;
         else if (accept) pend_q <= 1'b1;
         if (state_q == IDLE && accept) begin
            cnt_q <= cnt_in;
            idx_q <= '0;
         end else if (rx_hit) begin
            idx_q <= idx_q + CW'(1);
         end
         if (rx_hit) begin
            rx_byte_q <= i_MISO_Byte;
            rx_cnt_q  <= idx_q;
         end
      end
   end

   assign o_TX_Ready  = tx_rdy_q;
   assign o_MOSI_DV   = mosi_dv_q;
   assign o_MOSI_Byte = byte_q;
   assign o_CS_n      = cs_n_q;
   assign o_Abort     = abort_q;
   assign o_RX_DV     = rx_dv_q;
   assign o_RX_Byte   = rx_byte_q;
   assign o_RX_Count  = rx_cnt_q;

endmodule

// File: tb/tb_spi_cs_txn_ctrl.sv
// Bench for spi_cs_txn_ctrl with a behavioural SPI_Master stand-in (MISO looped to MOSI, 64 clks per byte).
module tb_spi_cs_txn_ctrl;

   localparam int CW        = 2;
   localparam int XFER_CLKS = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] i_TX_Count;
   logic [7:0]    i_TX_Byte;
   logic          i_TX_DV;
   logic          o_TX_Ready;
   logic [CW-1:0] o_RX_Count;
   logic          o_RX_DV;
   logic [7:0]    o_RX_Byte;
   logic [7:0]    o_MOSI_Byte;
   logic          o_MOSI_DV;
   logic          i_MOSI_Ready;
   logic          i_MISO_DV;
   logic [7:0]    i_MISO_Byte;
   logic          o_CS_n;
   logic          o_Abort;

   always #5 clk = ~clk;

   spi_cs_txn_ctrl #(
      .MAX_BYTES_PER_CS (2),
      .CS_SETUP_CLKS    (2),
      .CS_HOLD_CLKS     (2),
      .CS_INACTIVE_CLKS (4),
      .TIMEOUT_CLKS     (256)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_TX_Count   (i_TX_Count),
      .i_TX_Byte    (i_TX_Byte),
      .i_TX_DV      (i_TX_DV),
      .o_TX_Ready   (o_TX_Ready),
      .o_RX_Count   (o_RX_Count),
      .o_RX_DV      (o_RX_DV),
      .o_RX_Byte    (o_RX_Byte),
      .o_MOSI_Byte  (o_MOSI_Byte),
      .o_MOSI_DV    (o_MOSI_DV),
      .i_MOSI_Ready (i_MOSI_Ready),
      .i_MISO_DV    (i_MISO_DV),
      .i_MISO_Byte  (i_MISO_Byte),
      .o_CS_n       (o_CS_n),
      .o_Abort      (o_Abort)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Scoreboard entries: {index, byte}
   logic [15:0] exp_q[$];

   int cyc = 0, t_fall = 0, t_rise = 0, t_mosi = 0, t_rx = 0, t_abort = 0, t_rdy_rise = 0;
   int mosi_cnt = 0, rx_cnt = 0, abort_cnt = 0, cs_rises = 0;
   bit cs_prev = 1'b1, rdy_prev = 1'b0, first_mosi_pend = 1'b0;

   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (cs_prev && !o_CS_n) begin t_fall = cyc; first_mosi_pend = 1'b1; end
         if (!cs_prev && o_CS_n) begin t_rise = cyc; cs_rises++; end
         cs_prev = o_CS_n;
         if (o_MOSI_DV) begin
            mosi_cnt++;
            if (first_mosi_pend) begin t_mosi = cyc; first_mosi_pend = 1'b0; end
         end
         if (o_RX_DV) begin
            rx_cnt++;
            t_rx = cyc;
            check_eq("rx_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_eq("rx_byte", o_RX_Byte, e[7:0]);
               check_eq("rx_index", o_RX_Count, e[15:8]);
            end
         end
         if (o_Abort) begin abort_cnt++; t_abort = cyc; end
         if (o_TX_Ready && !rdy_prev) t_rdy_rise = cyc;
         rdy_prev = o_TX_Ready;
      end
   end

   // SPI_Master stand-in: takes a byte on o_MOSI_DV, echoes it on i_MISO_DV XFER_CLKS later.
   bit model_flush = 1'b1;
   initial begin
      bit         busy;
      int         cnt;
      logic [7:0] lat;
      busy = 1'b0; cnt = 0; lat = '0;
      i_MOSI_Ready = 1'b1; i_MISO_DV = 1'b0; i_MISO_Byte = '0;
      forever begin
         @(posedge clk);
         #1;
         i_MISO_DV = 1'b0;
         if (model_flush) begin
            busy = 1'b0;
            i_MOSI_Ready = 1'b1;
         end else begin
            if (o_MOSI_DV) check_eq("mosi_dv_needs_ready", i_MOSI_Ready, 1);
            if (busy) begin
               cnt--;
               if (cnt == 0) begin
                  busy = 1'b0; i_MISO_DV = 1'b1; i_MISO_Byte = lat; i_MOSI_Ready = 1'b1;
               end
            end
            if (o_MOSI_DV) begin
               busy = 1'b1; cnt = XFER_CLKS; lat = o_MOSI_Byte; i_MOSI_Ready = 1'b0;
            end
         end
      end
   end

   task automatic send(input logic [7:0] b, input logic [CW-1:0] cnt, input int idx, input bit expect_rx);
      int n = 0;
      while (o_TX_Ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      check_eq("send_ready_seen", o_TX_Ready, 1);
      i_TX_DV = 1'b1; i_TX_Byte = b; i_TX_Count = cnt;
      if (expect_rx) exp_q.push_back({8'(idx), b});
      @(negedge clk);
      i_TX_DV = 1'b0;
   endtask

   task automatic wait_rise(input int r0, input string tag);
      int n = 0;
      while (cs_rises == r0 && n < 2000) begin @(negedge clk); n++; end
      check_eq(tag, cs_rises, r0 + 1);
   endtask

   int m0, x0, r0, a0, prev_rise, n;

   initial begin
      rst = 1'b0; i_TX_DV = 1'b0; i_TX_Byte = '0; i_TX_Count = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_cs_n", o_CS_n, 1);
      check_eq("rst_tx_ready", o_TX_Ready, 0);
      check_eq("rst_mosi_dv", o_MOSI_DV, 0);
      check_eq("rst_rx_dv", o_RX_DV, 0);
      check_eq("rst_abort", o_Abort, 0);
      check_eq("rst_rx_byte", o_RX_Byte, 0);
      check_eq("rst_rx_count", o_RX_Count, 0);
      rst = 1'b1; model_flush = 1'b0;
      @(negedge clk);
      check_eq("rst_release_ready", o_TX_Ready, 1);

      // 1: single byte
      m0 = mosi_cnt; x0 = rx_cnt; r0 = cs_rises;
      send(8'h37, 2'd1, 0, 1'b1);
      wait_rise(r0, "t1_cs_rise");
      check_eq("t1_mosi_pulses", mosi_cnt - m0, 1);
      check_eq("t1_rx_pulses", rx_cnt - x0, 1);
      check_eq("t1_setup_gap", t_mosi - t_fall, 2);
      check_eq("t1_hold_gap", t_rise - t_rx, 2);
      prev_rise = t_rise;

      // 2: two bytes under one CS_n low
      m0 = mosi_cnt; x0 = rx_cnt; r0 = cs_rises;
      send(8'h38, 2'd2, 0, 1'b1);
      send(8'h39, 2'd1, 1, 1'b1);
      wait_rise(r0, "t2_cs_rise");
      check_eq("t2_rx_in_one_cs", rx_cnt - x0, 2);
      check_eq("t2_mosi_pulses", mosi_cnt - m0, 2);
      check_eq("t2_inactive_ge4", (t_fall - prev_rise) >= 4, 1);
      check_eq("t2_setup_gap", t_mosi - t_fall, 2);
      check_eq("t2_hold_gap", t_rise - t_rx, 2);

      // 4: count 0 acts as 1; byte offered during HOLD is dropped
      m0 = mosi_cnt; x0 = rx_cnt; r0 = cs_rises;
      send(8'h4C, 2'd0, 0, 1'b1);
      n = 0;
      while (!o_RX_DV && n < 1000) begin @(negedge clk); n++; end
      check_eq("t4_rx_seen", o_RX_DV, 1);
      i_TX_DV = 1'b1; i_TX_Byte = 8'hAA; i_TX_Count = 2'd1;
      @(negedge clk);
      i_TX_DV = 1'b0;
      wait_rise(r0, "t4_cs_rise");
      repeat (60) @(negedge clk);
      check_eq("t4_mosi_pulses", mosi_cnt - m0, 1);
      check_eq("t4_rx_pulses", rx_cnt - x0, 1);
      check_eq("t4_cs_stays_high", o_CS_n, 1);

      // 5: reset mid-transfer, then a clean transaction
      m0 = mosi_cnt;
      send(8'h21, 2'd2, 0, 1'b0);
      n = 0;
      while (mosi_cnt == m0 && n < 1000) begin @(negedge clk); n++; end
      repeat (5) @(negedge clk);
      check_eq("t5_cs_low_before_rst", o_CS_n, 0);
      rst = 1'b0; model_flush = 1'b1;
      @(negedge clk);
      check_eq("t5_rst_cs_n", o_CS_n, 1);
      check_eq("t5_rst_ready", o_TX_Ready, 0);
      rst = 1'b1; model_flush = 1'b0;
      @(negedge clk);
      check_eq("t5_release_ready", o_TX_Ready, 1);
      x0 = rx_cnt; r0 = cs_rises;
      send(8'h55, 2'd1, 0, 1'b1);
      wait_rise(r0, "t5_cs_rise");
      check_eq("t5_rx_pulses", rx_cnt - x0, 1);

`ifdef SPI_TXN_TIMEOUT_EN
      // 6: second byte withheld until timeout
      m0 = mosi_cnt; a0 = abort_cnt; r0 = cs_rises;
      send(8'h61, 2'd2, 0, 1'b1);
      n = 0;
      while (abort_cnt == a0 && n < 2000) begin @(negedge clk); n++; end
      check_eq("t6_abort_pulses", abort_cnt - a0, 1);
      check_eq("t6_timeout_len", t_abort - t_rdy_rise, 256);
      wait_rise(r0, "t6_cs_rise");
      check_eq("t6_hold_after_abort", t_rise - t_abort, 2);
      n = 0;
      while (!o_TX_Ready && n < 100) begin @(negedge clk); n++; end
      check_eq("t6_back_to_idle", o_TX_Ready, 1);
      check_eq("t6_mosi_pulses", mosi_cnt - m0, 1);
`else
      a0 = 0;
      check_eq("no_abort_default", abort_cnt, a0);
`endif

      check_eq("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
